// File: rtl/sw_led_pkg.sv
// Shared types and helpers for the switch/LED controller.
// Defines the per-channel LED mode encoding and the counter width helper.
package sw_led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_FOLLOW = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_GBLINK = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    // Counter width for a count range 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: two-flop synchroniser, stability counter and
// registered rising-edge pulse on the accepted level.
module sw_debounce
    import sw_led_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW,
    output logic SW_DB,
    output logic SW_RISE
);

    localparam int             CW      = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A mismatch must persist for DEB_CYCLES consecutive edges; any bounce clears the count.
    always_comb begin
        sync1_d = SW;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = {CW{1'b0}};
        if (sync2_q == db_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            db_d  = sync2_q;
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        rise_d = db_d & ~db_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign SW_DB   = db_q;
    assign SW_RISE = rise_q;

endmodule

// File: rtl/sw_led_ctrl.sv
// Multi-channel switch/LED controller: debounced switches, toggle state,
// shared blink generator and per-channel registered LED mode mux.
module sw_led_ctrl
    import sw_led_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DEB_CYCLES = 4,
    parameter int BLINK_HALF = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NCH-1:0]        SW,
    input  logic [MODE_W*NCH-1:0] MODE,
    output logic [NCH-1:0]        SW_DB,
    output logic [NCH-1:0]        SW_RISE,
    output logic [NCH-1:0]        LED,
    output logic                  ANY_ON
);

    localparam int            BW     = cnt_width(BLINK_HALF);
    localparam logic [BW-1:0] BL_MAX = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] BL_ONE = BW'(1);

    logic [NCH-1:0] sw_db;
    logic [NCH-1:0] sw_rise;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic           phase_q, phase_d;
    logic [NCH-1:0] tog_q, tog_d;
    logic [NCH-1:0] led_q, led_d;
    logic           any_on_q, any_on_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .CLK    (CLK),
            .RST    (RST),
            .SW     (SW[g]),
            .SW_DB  (sw_db[g]),
            .SW_RISE(sw_rise[g])
        );
    end

    // Free-running blink generator shared by every channel.
    always_comb begin
        bcnt_d  = bcnt_q + BL_ONE;
        phase_d = phase_q;
        if (bcnt_q == BL_MAX) begin
            bcnt_d  = {BW{1'b0}};
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + BL_ONE;
        end
    end

    // Toggle mode reads next-state toggle so the LED follows the rise pulse by one edge.
    always_comb begin
        tog_d = tog_q ^ sw_rise;
        led_d = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            case (mode_t'(MODE[MODE_W*i +: MODE_W]))
                MODE_FOLLOW: led_d[i] = sw_db[i];
                MODE_TOGGLE: led_d[i] = tog_d[i];
                MODE_GBLINK: led_d[i] = sw_db[i] & phase_q;
                MODE_BLINK:  led_d[i] = phase_q;
                default:     led_d[i] = 1'b0;
            endcase
        end
        any_on_d = |led_d;
    end

    // Top-level state register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bcnt_q   <= {BW{1'b0}};
            phase_q  <= 1'b0;
            tog_q    <= {NCH{1'b0}};
            led_q    <= {NCH{1'b0}};
            any_on_q <= 1'b0;
        end else begin
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            tog_q    <= tog_d;
            led_q    <= led_d;
            any_on_q <= any_on_d;
        end
    end

    assign SW_DB   = sw_db;
    assign SW_RISE = sw_rise;
    assign LED     = led_q;
    assign ANY_ON  = any_on_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl with NCH=4, DEB_CYCLES=4, BLINK_HALF=8.
module tb_sw_led_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] SW = 4'h0;
    logic [7:0] MODE = 8'h00;
    logic [3:0] SW_DB, SW_RISE, LED;
    logic       ANY_ON;

    int n_checks = 0;
    int n_fail   = 0;

    sw_led_ctrl #(.NCH(4), .DEB_CYCLES(4), .BLINK_HALF(8)) dut (
        .CLK(CLK), .RST(RST), .SW(SW), .MODE(MODE),
        .SW_DB(SW_DB), .SW_RISE(SW_RISE), .LED(LED), .ANY_ON(ANY_ON)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] e_db, e_rise, e_led;
        SW = 4'hF; MODE = 8'h00; RST = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_checks++;
            if ({SW_DB, SW_RISE, LED, ANY_ON} !== 13'h0) begin
                n_fail++;
                $display("FAIL reset_hold t=%0d got db=%h rise=%h led=%h any=%b want all 0", t, SW_DB, SW_RISE, LED, ANY_ON);
            end
        end
        RST = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            e_db   = (t >= 6) ? 4'hF : 4'h0;
            e_rise = (t == 6) ? 4'hF : 4'h0;
            e_led  = (t >= 7) ? 4'hF : 4'h0;
            n_checks++;
            if (SW_DB !== e_db || SW_RISE !== e_rise || LED !== e_led || ANY_ON !== (t >= 7)) begin
                n_fail++;
                $display("FAIL reset_release t=%0d got db=%h rise=%h led=%h any=%b want db=%h rise=%h led=%h any=%b",
                         t, SW_DB, SW_RISE, LED, ANY_ON, e_db, e_rise, e_led, (t >= 7));
            end
        end
    endtask

    task automatic test_glitch;
        int rises;
        SW = 4'h0; MODE = 8'h00;
        apply_reset();
        repeat (2) tick();
        SW[0] = 1'b1;
        for (int t = 0; t < 11; t++) begin
            tick();
            if (t == 2) SW[0] = 1'b0;
            n_checks++;
            if (SW_DB[0] !== 1'b0 || SW_RISE[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_reject t=%0d got db=%b rise=%b want 0 0", t, SW_DB[0], SW_RISE[0]);
            end
        end
        SW[0] = 1'b1;
        rises = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (SW_RISE[0] === 1'b1) rises++;
            n_checks++;
            if (SW_DB[0] !== (t >= 6) || SW_RISE[0] !== (t == 6)) begin
                n_fail++;
                $display("FAIL glitch_hold t=%0d got db=%b rise=%b want db=%b rise=%b", t, SW_DB[0], SW_RISE[0], (t >= 6), (t == 6));
            end
        end
        n_checks++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL glitch_rise_count got %0d want 1", rises);
        end
    endtask

    task automatic test_toggle;
        logic exp_led;
        SW = 4'h0; MODE = 8'h01;
        apply_reset();
        exp_led = 1'b0;
        for (int p = 0; p < 3; p++) begin
            SW[0] = 1'b1;
            for (int t = 1; t <= 16; t++) begin
                tick();
                if (t == 8) SW[0] = 1'b0;
                if (t == 6) begin
                    n_checks++;
                    if (SW_RISE[0] !== 1'b1 || LED[0] !== exp_led) begin
                        n_fail++;
                        $display("FAIL toggle_rise p=%0d got rise=%b led=%b want rise=1 led=%b", p, SW_RISE[0], LED[0], exp_led);
                    end
                    exp_led = ~exp_led;
                end
                if (t == 7 || t == 16) begin
                    n_checks++;
                    if (LED !== {3'b000, exp_led}) begin
                        n_fail++;
                        $display("FAIL toggle_led p=%0d t=%0d got %h want %h", p, t, LED, {3'b000, exp_led});
                    end
                end
            end
        end
    endtask

    task automatic test_blink;
        logic [3:0] e_led;
        SW = 4'h0; MODE = 8'hFF;
        apply_reset();
        for (int t = 1; t <= 26; t++) begin
            tick();
            e_led = ((((t - 1) / 8) % 2) == 1) ? 4'hF : 4'h0;
            n_checks++;
            if (LED !== e_led || ANY_ON !== (e_led != 4'h0)) begin
                n_fail++;
                $display("FAIL blink t=%0d got led=%h any=%b want led=%h", t, LED, ANY_ON, e_led);
            end
        end
    endtask

    function automatic logic gb_db(input int t);
        return ((t >= 6) && (t < 26)) || (t >= 36);
    endfunction

    function automatic logic gb_phase(input int t);
        return ((t / 8) % 2) == 1;
    endfunction

    task automatic test_gated_blink;
        logic e2;
        SW = 4'b0100; MODE = 8'h20;
        apply_reset();
        for (int t = 1; t <= 44; t++) begin
            tick();
            if (t == 20) SW[2] = 1'b0;
            if (t == 30) SW[2] = 1'b1;
            e2 = gb_db(t - 1) & gb_phase(t - 1);
            n_checks++;
            if (LED !== {1'b0, e2, 2'b00} || ANY_ON !== e2 || SW_DB[2] !== gb_db(t)) begin
                n_fail++;
                $display("FAIL gated_blink t=%0d got led=%h any=%b db=%b want led=%h db=%b",
                         t, LED, ANY_ON, SW_DB[2], {1'b0, e2, 2'b00}, gb_db(t));
            end
        end
    endtask

    task automatic test_reset_mid;
        SW = 4'h0; MODE = 8'hFC;
        apply_reset();
        repeat (10) tick();
        SW[0] = 1'b1;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        n_checks++;
        if ({SW_DB, SW_RISE, LED, ANY_ON} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_mid got db=%h rise=%h led=%h any=%b want all 0", SW_DB, SW_RISE, LED, ANY_ON);
        end
        RST = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            n_checks++;
            if (SW_DB[0] !== (t >= 6)) begin
                n_fail++;
                $display("FAIL reset_mid_deb t=%0d got %b want %b", t, SW_DB[0], (t >= 6));
            end
            if (t == 8) begin
                n_checks++;
                if (LED !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL reset_mid_blink8 got %h want 1", LED);
                end
            end
            if (t == 9) begin
                n_checks++;
                if (LED !== 4'hF || ANY_ON !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_mid_blink9 got led=%h any=%b want f 1", LED, ANY_ON);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_toggle();
        test_blink();
        test_gated_blink();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_led_ctrl.md
Name: sw_led_ctrl

Overview:
- Parametrised, multi-channel successor to the board-level switch/LED glue block.
- Each of NCH channels synchronises and debounces a raw switch input and drives one LED.
- The LED is driven in one of four per-channel modes: follow, toggle, gated blink, free blink.
- Sits between board pins (SW, LED) and the rest of the FPGA top level. It also exports clean switch levels and rising-edge pulses for other logic.

Parameters:
- NCH, 4, number of switch/LED channels (>=1).
- DEB_CYCLES, 4, consecutive stable cycles required before a switch change is accepted (>=1).
- BLINK_HALF, 8, blink half-period in clock cycles; full period is 2*BLINK_HALF (>=2).

Ports:
- CLK  in  1  system clock (50 MHz on board).
- RST  in  1  synchronous, active-high reset.
- SW  in  NCH  raw asynchronous switch inputs.
- MODE  in  2*NCH  per-channel mode; channel i uses MODE[2i+1:2i]; must be synchronous to CLK.
- SW_DB  out  NCH  debounced switch levels.
- SW_RISE  out  NCH  one-cycle pulse on each debounced 0->1 transition.
- LED  out  NCH  registered LED drive.
- ANY_ON  out  1  registered OR of all LED bits.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. All state updates on the rising edge of CLK.
- Reset values: every output is 0; synchroniser flops, debounce counters, toggle state and blink counter/phase are all 0.
- Synchroniser: two flops per channel, giving sync[i].
- Debounce, per channel:
  - if sync == SW_DB, the counter is cleared;
  - otherwise the counter increments;
  - on the edge where the counter == DEB_CYCLES-1 while still mismatched, SW_DB takes sync and the counter clears.
- Debounce boundary behaviour:
  - Any bounce (sync returning to SW_DB) restarts the count.
  - Latency: new SW value sampled at edge k means SW_DB updates at edge k+DEB_CYCLES+1, provided SW is held.
- SW_RISE[i] is registered and high for exactly the cycle in which SW_DB[i] has just gone 0->1. There is no pulse on 1->0.
- Switch held high through reset: after RST falls, SW_DB rises after the normal latency and SW_RISE pulses once.
- Toggle state tog[i]: inverts on every cycle SW_RISE[i]=1, in all modes. It is retained across mode changes.
- Blink generator, shared by all channels:
  - counter runs 0..BLINK_HALF-1; on the wrap edge, phase inverts.
  - After reset release, the first phase toggle is on the BLINK_HALF-th edge.
  - The counter and phase free-run regardless of MODE.
- LED[i] is registered one edge after its sources, selected by MODE:
  - 00 FOLLOW: SW_DB[i].
  - 01 TOGGLE: tog[i].
  - 10 GATED_BLINK: SW_DB[i] & phase.
  - 11 BLINK: phase.
- MODE change: takes effect on LED at the next edge. There is no glitch beyond that one-cycle latency.
- ANY_ON is registered from the next-state LED vector, so it is coincident with LED.
- RST asserted mid-operation: all state returns to reset values at that edge, and any pending debounce count is discarded.
- Width rules: counter widths are $clog2 of DEB_CYCLES and BLINK_HALF respectively, minimum 1 bit. No overflow is possible by construction.

Decomposition:
- Package sw_led_pkg:
  - mode_t enum (MODE_FOLLOW=2'b00, MODE_TOGGLE=2'b01, MODE_GBLINK=2'b10, MODE_BLINK=2'b11);
  - localparam MODE_W=2.
- Sub-module sw_debounce (params DEB_CYCLES; ports CLK, RST, SW, SW_DB, SW_RISE) contains the synchroniser, debounce counter and edge detector. It is instantiated NCH times in a generate loop.
- The top level holds the shared blink generator, tog registers, LED mux and ANY_ON.

Test Plan (NCH=4, DEB_CYCLES=4, BLINK_HALF=8):
- Reset with SW=4'hF held -> all outputs 0 while RST=1; after release, SW_DB=4'hF after 5 edges, SW_RISE=4'hF for one cycle, LED=4'hF one edge later (MODE all FOLLOW).
- SW[0] pulses high for 3 cycles, then holds high for 10 -> the 3-cycle glitch is rejected; SW_DB[0] rises exactly 5 edges after the start of the hold; a single SW_RISE[0] pulse.
- MODE[1:0]=TOGGLE, three clean presses on SW[0] -> LED[0] goes 1,0,1; each change lands one edge after SW_RISE[0].
- MODE=all BLINK from reset -> LED=4'hF and 4'h0 alternating every 8 cycles; first rise on edge 9 after release; ANY_ON tracks LED.
- Channel 2 in GATED_BLINK with SW[2] toggling -> LED[2] = phase only while SW_DB[2]=1, else 0.
- RST asserted mid-debounce (counter=2) and mid-blink -> next edge all outputs 0, counters 0; a fresh full latency is needed afterwards.
